vpg_mode_sequencer: RTL and testbench

//  Sequences a video-mode change for the pattern-generator subsystem on clk_50.

---
 rtl/vpg_mode_sequencer_if.sv | 8 +
 rtl/vpg_mode_sequencer.sv | 95 +++++++++
 tb/tb_vpg_mode_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/vpg_mode_sequencer_if.sv
// vpg_mode_sequencer_if: mode-change request handshake (valid/ready plus requested mode)
interface vpg_mode_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_mode;
  modport master (output req_valid, output req_mode, input req_ready);
  modport slave (input req_valid, input req_mode, output req_ready);
endinterface

// File: rtl/vpg_mode_sequencer.sv
// vpg_mode_sequencer: frame-aligned blank, mode update, PLL pulse and lock wait for video mode changes
module vpg_mode_sequencer #(
  parameter logic [3:0] DEFAULT_MODE   = 4'd0,
  parameter int         VS_TIMEOUT     = 1_000_000,
  parameter int         UNLOCK_TIMEOUT = 256,
  parameter int         LOCK_TIMEOUT   = 500_000,
  parameter int         SETTLE_CYCLES  = 1024
) (
  input  logic                 clk_50,
  input  logic                 reset,
  vpg_mode_sequencer_if.slave  req,
  input  logic                 vs_in,
  input  logic                 pll_locked,
  output logic [3:0]           mode,
  output logic                 mode_change,
  output logic                 blank,
  output logic                 busy,
  output logic                 lock_err
);
  typedef enum logic [2:0] {IDLE, WAIT_VS, BLANK, RECONFIG, WAIT_UNLOCK, WAIT_LOCK, SETTLE} state_t;
  localparam logic [19:0] VS_LAST     = 20'(VS_TIMEOUT - 1);
  localparam logic [19:0] UNLOCK_LAST = 20'(UNLOCK_TIMEOUT - 1);
  localparam logic [19:0] LOCK_LAST   = 20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0] SETTLE_LAST = 20'(SETTLE_CYCLES - 1);
  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  mode_q, mode_d, next_mode_q, next_mode_d;
  logic        lock_err_q, lock_err_d;
  logic        vs_s1_q, vs_s2_q, vs_d1_q, lk_s1_q, lk_s2_q;
  logic        accept, vs_rise;
  assign accept      = req.req_valid && state_q == IDLE;
  assign vs_rise     = vs_s2_q && !vs_d1_q;
  assign req.req_ready = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign blank       = !(state_q == IDLE || state_q == WAIT_VS);
  assign mode_change = state_q == RECONFIG;
  assign mode        = mode_q;
  assign lock_err    = lock_err_q;
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      mode_q      <= DEFAULT_MODE;
      next_mode_q <= DEFAULT_MODE;
      lock_err_q  <= 1'b0;
      vs_s1_q     <= 1'b0;
      vs_s2_q     <= 1'b0;
      vs_d1_q     <= 1'b0;
      lk_s1_q     <= 1'b0;
      lk_s2_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      next_mode_q <= next_mode_d;
      lock_err_q  <= lock_err_d;
      vs_s1_q     <= vs_in;
      vs_s2_q     <= vs_s1_q;
      vs_d1_q     <= vs_s2_q;
      lk_s1_q     <= pll_locked;
      lk_s2_q     <= lk_s1_q;
    end
  end
  // mode is loaded on BLANK->RECONFIG so the new code is visible during the mode_change pulse
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    next_mode_d = next_mode_q;
    lock_err_d  = lock_err_q;
    case (state_q)
      IDLE: if (accept) begin
        lock_err_d = 1'b0;
        if (req.req_mode != mode_q) begin
          next_mode_d = req.req_mode;
          state_d     = WAIT_VS;
        end
      end
      WAIT_VS:     state_d = (vs_rise || cnt_q == VS_LAST) ? BLANK : WAIT_VS;
      BLANK: begin
        state_d = RECONFIG;
        mode_d  = next_mode_q;
      end
      RECONFIG:    state_d = WAIT_UNLOCK;
      WAIT_UNLOCK: state_d = (!lk_s2_q || cnt_q == UNLOCK_LAST) ? WAIT_LOCK : WAIT_UNLOCK;
      WAIT_LOCK: if (lk_s2_q) state_d = SETTLE;
        else if (cnt_q == LOCK_LAST) begin
          lock_err_d = 1'b1;
          state_d    = IDLE;
        end
      SETTLE:      state_d = !lk_s2_q ? WAIT_LOCK : (cnt_q == SETTLE_LAST) ? IDLE : SETTLE;
      default:     state_d = WAIT_LOCK;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 20'd1;
  end
endmodule

// File: tb/tb_vpg_mode_sequencer.sv
// tb_vpg_mode_sequencer: directed checks of reset, mode change, same-mode, vs/lock timeouts, settle glitch and mid-op reset
module tb_vpg_mode_sequencer;
  logic       clk_50 = 1'b0;
  logic       reset, vs_in, pll_locked;
  logic [3:0] mode;
  logic       mode_change, blank, busy, lock_err;
  int         total = 0, bad = 0, pulses = 0, dbl = 0;
  logic [3:0] pulse_mode = 4'hf;
  logic       prev_mc = 1'b0;
  vpg_mode_sequencer_if rif();
  vpg_mode_sequencer #(
    .DEFAULT_MODE(4'd0), .VS_TIMEOUT(64), .UNLOCK_TIMEOUT(16),
    .LOCK_TIMEOUT(128), .SETTLE_CYCLES(8)
  ) dut (
    .clk_50(clk_50), .reset(reset), .req(rif), .vs_in(vs_in), .pll_locked(pll_locked),
    .mode(mode), .mode_change(mode_change), .blank(blank), .busy(busy), .lock_err(lock_err)
  );
  always #10 clk_50 = ~clk_50;
  always @(negedge clk_50) begin
    if (mode_change) begin
      pulses++;
      pulse_mode = mode;
    end
    if (mode_change && prev_mc) dbl++;
    prev_mc = mode_change;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk_50);
  endtask
  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (rif.req_ready !== 1'b1 && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, 32'(rif.req_ready), 32'd1);
  endtask
  task automatic request(input logic [3:0] m);
    rif.req_mode  = m;
    rif.req_valid = 1'b1;
    step(1);
    rif.req_valid = 1'b0;
  endtask
  initial begin
    reset = 1'b1; pll_locked = 1'b1; vs_in = 1'b0;
    rif.req_valid = 1'b0; rif.req_mode = 4'd0;
    step(2);
    chk("rst_blank", 32'(blank), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(rif.req_ready), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_pulse", 32'(mode_change), 32'd0);
    chk("rst_err", 32'(lock_err), 32'd0);
    // T1: two sync cycles, one WAIT_LOCK cycle, 8 settle cycles
    reset = 1'b0;
    step(10);
    chk("t1_still_busy", 32'(busy), 32'd1);
    chk("t1_still_blank", 32'(blank), 32'd1);
    step(1);
    chk("t1_ready", 32'(rif.req_ready), 32'd1);
    chk("t1_unblank", 32'(blank), 32'd0);
    chk("t1_mode", 32'(mode), 32'd0);
    // T2: mode 3 with vs edge and a real lock drop/return
    request(4'd3);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_ready_low", 32'(rif.req_ready), 32'd0);
    chk("t2_no_blank_yet", 32'(blank), 32'd0);
    step(9);
    chk("t2_wait_vs", 32'(blank), 32'd0);
    vs_in = 1'b1;
    step(2);
    chk("t2_vs_sync", 32'(blank), 32'd0);
    step(1);
    chk("t2_blank", 32'(blank), 32'd1);
    chk("t2_pre_pulse", 32'(mode_change), 32'd0);
    step(1);
    chk("t2_pulse", 32'(mode_change), 32'd1);
    chk("t2_mode_in_pulse", 32'(mode), 32'd3);
    pll_locked = 1'b0;
    step(1);
    chk("t2_pulse_end", 32'(mode_change), 32'd0);
    vs_in = 1'b0;
    step(20);
    chk("t2_lock_wait", 32'(blank), 32'd1);
    pll_locked = 1'b1;
    step(10);
    chk("t2_settling", 32'(busy), 32'd1);
    step(1);
    chk("t2_idle", 32'(rif.req_ready), 32'd1);
    chk("t2_unblank", 32'(blank), 32'd0);
    chk("t2_pulses", 32'(pulses), 32'd1);
    chk("t2_pulse_mode", 32'(pulse_mode), 32'd3);
    // T3: same mode is accepted without a sequence
    rif.req_mode = 4'd3; rif.req_valid = 1'b1;
    step(3);
    rif.req_valid = 1'b0;
    chk("t3_ready", 32'(rif.req_ready), 32'd1);
    chk("t3_blank", 32'(blank), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_pulses", 32'(pulses), 32'd1);
    // T4: no vsync, BLANK exactly 64 cycles after accept
    request(4'd5);
    step(63);
    chk("t4_before_to", 32'(blank), 32'd0);
    step(1);
    chk("t4_blank_at_64", 32'(blank), 32'd1);
    step(1);
    chk("t4_pulse", 32'(mode_change), 32'd1);
    chk("t4_mode", 32'(mode), 32'd5);
    wait_idle("t4_idle_to", 100);
    chk("t4_pulses", 32'(pulses), 32'd2);
    chk("t4_err", 32'(lock_err), 32'd0);
    // T5: lock never returns
    pll_locked = 1'b0;
    step(3);
    request(4'd7);
    wait_idle("t5_idle_to", 400);
    chk("t5_err", 32'(lock_err), 32'd1);
    chk("t5_mode", 32'(mode), 32'd7);
    chk("t5_unblank", 32'(blank), 32'd0);
    step(2);
    chk("t5_err_sticky", 32'(lock_err), 32'd1);
    request(4'd7);
    chk("t5_err_clr", 32'(lock_err), 32'd0);
    chk("t5_pulses", 32'(pulses), 32'd3);
    // T6: accept A, BLANK A+64, WAIT_UNLOCK A+66, WAIT_LOCK A+82, SETTLE A+83, would idle at A+91
    pll_locked = 1'b1;
    step(3);
    request(4'd9);
    step(84);
    chk("t6_in_settle", 32'(busy), 32'd1);
    pll_locked = 1'b0;
    step(10);
    chk("t6_glitch_busy", 32'(busy), 32'd1);
    chk("t6_glitch_blank", 32'(blank), 32'd1);
    chk("t6_mode", 32'(mode), 32'd9);
    reset = 1'b1;
    step(1);
    chk("t6_rst_mode", 32'(mode), 32'd0);
    chk("t6_rst_pulse", 32'(mode_change), 32'd0);
    chk("t6_rst_blank", 32'(blank), 32'd1);
    chk("t6_rst_ready", 32'(rif.req_ready), 32'd0);
    chk("t6_pulses", 32'(pulses), 32'd4);
    reset = 1'b0;
    pll_locked = 1'b1;
    wait_idle("t6_idle_to", 50);
    chk("t6_final_mode", 32'(mode), 32'd0);
    chk("t6_final_pulses", 32'(pulses), 32'd4);
    chk("no_double_pulse", 32'(dbl), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
